prog_loader: RTL and testbench

Program-load controller for the 8-bit CPU's 32-entry instruction memory. Accepts a framed byte stream over a valid/ready handshake and clears the instruction memory. Drives its write port (`mem_WR`/`mem_data`) one byte per handshake, verifies a checksum, then releases the CPU with `cpu_run`. It sits between the host byte receiver and the instruction memory; the CPU fetch path (PC-indexed read) is untouched.

---
 rtl/prog_loader.sv | 131 +++++++++++++
 tb/tb_prog_loader.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Program-load controller: receives a framed byte stream (sync, length, payload,
// checksum), writes the payload into instruction memory and releases the CPU.
module prog_loader #(
  parameter int          LENGTH     = 32,
  parameter logic [7:0]  START_BYTE = 8'hA5,
  parameter int          TIMEOUT    = 255
) (
  input  logic       CPU_Clk,
  input  logic       Reset,
  input  logic       load_req,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  input  logic       mem_full,
  output logic       mem_clear,
  output logic       mem_WR,
  output logic [7:0] mem_data,
  output logic [5:0] byte_count,
  output logic       busy,
  output logic       cpu_run,
  output logic       error,
  output logic [1:0] err_code
);

  typedef enum logic [2:0] {IDLE, CLEAR, SYNC, LEN, DATA, CSUM, RUN, ERR} state_t;

  state_t     state, state_n;
  logic [7:0] csum, timer, sum_c;
  logic [5:0] remaining;
  logic [1:0] code_n;
  logic       hs, timed, tmo;

  always_comb begin
    rx_ready = 1'b0;
    case (state)
      SYNC, LEN, CSUM: rx_ready = 1'b1;
      DATA:            rx_ready = !mem_full;
      default:         rx_ready = 1'b0;
    endcase
  end

  assign hs       = rx_valid && rx_ready;
  assign mem_WR   = (state == DATA) && hs;
  assign mem_data = rx_data;
  assign sum_c    = csum + rx_data;
  assign timed    = (state == LEN) || (state == DATA) || (state == CSUM);
  // Fires on the idle edge that would take the counter to TIMEOUT.
  assign tmo      = timed && !hs && (timer == 8'(TIMEOUT - 1));

  always_comb begin
    state_n = state;
    code_n  = err_code;
    case (state)
      IDLE:  if (load_req) state_n = CLEAR;
      CLEAR: state_n = SYNC;
      SYNC:  if (hs && rx_data == START_BYTE) state_n = LEN;
      LEN: begin
        if (hs) begin
          if (rx_data == 8'd0 || rx_data > 8'(LENGTH - 1)) begin
            state_n = ERR; code_n = 2'd1;
          end else begin
            state_n = DATA;
          end
        end else if (tmo) begin
          state_n = ERR; code_n = 2'd3;
        end
      end
      DATA: begin
        if (mem_full) begin
          state_n = ERR; code_n = 2'd1;
        end else if (hs) begin
          if (remaining == 6'd1) state_n = CSUM;
        end else if (tmo) begin
          state_n = ERR; code_n = 2'd3;
        end
      end
      CSUM: begin
        if (hs) begin
          if (sum_c == 8'd0) state_n = RUN;
          else begin state_n = ERR; code_n = 2'd2; end
        end else if (tmo) begin
          state_n = ERR; code_n = 2'd3;
        end
      end
      default: state_n = state;
    endcase
    // A reload request overrides everything except an in-progress clear.
    if (load_req && state != CLEAR) state_n = CLEAR;
    if (state_n == CLEAR) code_n = 2'd0;
  end

  always_ff @(posedge CPU_Clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      mem_clear  <= 1'b0;
      busy       <= 1'b0;
      cpu_run    <= 1'b0;
      error      <= 1'b0;
      err_code   <= 2'd0;
      byte_count <= 6'd0;
      csum       <= 8'd0;
      timer      <= 8'd0;
      remaining  <= 6'd0;
    end else begin
      state     <= state_n;
      err_code  <= code_n;
      mem_clear <= (state_n == CLEAR);
      busy      <= (state_n == CLEAR) || (state_n == SYNC) || (state_n == LEN) ||
                   (state_n == DATA)  || (state_n == CSUM);
      cpu_run   <= (state_n == RUN);
      error     <= (state_n == ERR);

      if (state_n != state || hs || !timed) timer <= 8'd0;
      else                                  timer <= timer + 8'd1;

      if (state_n == CLEAR) begin
        byte_count <= 6'd0;
        csum       <= 8'd0;
        remaining  <= 6'd0;
      end else if (state == LEN && hs) begin
        remaining <= rx_data[5:0];
        csum      <= 8'd0;
      end else if (state == DATA && hs) begin
        csum      <= sum_c;
        remaining <= remaining - 6'd1;
        if (byte_count != 6'(LENGTH - 1)) byte_count <= byte_count + 6'd1;
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader; payload writes are scoreboarded through a queue.
module tb_prog_loader;

  logic       CPU_Clk = 1'b0;
  logic       Reset, load_req, rx_valid, mem_full;
  logic [7:0] rx_data;
  logic       rx_ready, mem_clear, mem_WR, busy, cpu_run, error;
  logic [7:0] mem_data;
  logic [5:0] byte_count;
  logic [1:0] err_code;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];

  always #5 CPU_Clk = ~CPU_Clk;

  prog_loader dut (
    .CPU_Clk(CPU_Clk), .Reset(Reset), .load_req(load_req),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .mem_full(mem_full), .mem_clear(mem_clear), .mem_WR(mem_WR),
    .mem_data(mem_data), .byte_count(byte_count), .busy(busy),
    .cpu_run(cpu_run), .error(error), .err_code(err_code)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Checks any memory write against the scoreboard mid-cycle, then advances one edge.
  task automatic tick();
    int n;
    @(negedge CPU_Clk);
    if (mem_WR) begin
      n = exp_q.size();
      chk("wr_expected", n != 0, 1);
      if (n != 0) chk("wr_data", mem_data, exp_q.pop_front());
    end
    @(posedge CPU_Clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input bit wr);
    rx_valid = 1'b1;
    rx_data  = b;
    if (wr) exp_q.push_back(b);
    tick();
  endtask

  task automatic reload();
    rx_valid = 1'b0;
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    chk("reload_clear", mem_clear, 1);
    tick();
  endtask

  initial begin
    Reset = 1'b1; load_req = 1'b0; rx_valid = 1'b0; mem_full = 1'b0; rx_data = 8'h00;
    #2;
    chk("rst_ready", rx_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_run", cpu_run, 0);
    chk("rst_err", error, 0);
    chk("rst_code", err_code, 0);
    chk("rst_count", byte_count, 0);
    chk("rst_clear", mem_clear, 0);
    @(posedge CPU_Clk); #1;
    Reset = 1'b0;
    tick();

    // Basic frame, continuous valid
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    chk("t1_clear", mem_clear, 1);
    chk("t1_busy", busy, 1);
    chk("t1_ready_clear", rx_ready, 0);
    tick();
    chk("t1_clear_off", mem_clear, 0);
    chk("t1_ready_sync", rx_ready, 1);
    send(8'hA5, 0); send(8'h03, 0);
    send(8'h11, 1); send(8'h22, 1); send(8'h33, 1);
    send(8'h9A, 0);
    rx_valid = 1'b0;
    chk("t1_run", cpu_run, 1);
    chk("t1_err", error, 0);
    chk("t1_count", byte_count, 3);
    chk("t1_busy_off", busy, 0);
    chk("t1_drain", exp_q.size(), 0);

    // Garbage before sync is discarded
    reload();
    send(8'h00, 0); send(8'h7F, 0); send(8'hA5, 0); send(8'h01, 0);
    send(8'h05, 1); send(8'hFB, 0);
    rx_valid = 1'b0;
    chk("t2_run", cpu_run, 1);
    chk("t2_count", byte_count, 1);
    chk("t2_drain", exp_q.size(), 0);

    // Checksum failure, then recovery
    reload();
    send(8'hA5, 0); send(8'h02, 0); send(8'h10, 1); send(8'h20, 1); send(8'h00, 0);
    rx_valid = 1'b0;
    chk("t3_err", error, 1);
    chk("t3_code", err_code, 2);
    chk("t3_run", cpu_run, 0);
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    chk("t3_err_clr", error, 0);
    chk("t3_clear", mem_clear, 1);
    tick();
    chk("t3_code_clr", err_code, 0);

    // Bad lengths
    send(8'hA5, 0); send(8'h00, 0);
    rx_valid = 1'b0;
    chk("t4_len0_err", error, 1);
    chk("t4_len0_code", err_code, 1);
    reload();
    send(8'hA5, 0); send(8'h20, 0);
    rx_valid = 1'b0;
    chk("t4_len32_code", err_code, 1);
    chk("t4_drain", exp_q.size(), 0);

    // Maximum payload of 31 bytes
    reload();
    send(8'hA5, 0); send(8'h1F, 0);
    for (int i = 0; i < 31; i++) send(8'h01, 1);
    send(8'hE1, 0);
    rx_valid = 1'b0;
    chk("t5_run", cpu_run, 1);
    chk("t5_count", byte_count, 31);
    chk("t5_drain", exp_q.size(), 0);

    // Memory full while payload remains
    reload();
    send(8'hA5, 0); send(8'h02, 0); send(8'h07, 1);
    mem_full = 1'b1;
    chk("t6_ready", rx_ready, 0);
    tick();
    mem_full = 1'b0; rx_valid = 1'b0;
    chk("t6_code", err_code, 1);
    chk("t6_err", error, 1);

    // Timeout after exactly 255 idle cycles
    reload();
    send(8'hA5, 0); send(8'h04, 0); send(8'h01, 1);
    rx_valid = 1'b0;
    for (int i = 0; i < 254; i++) tick();
    chk("t7_no_err_254", error, 0);
    tick();
    chk("t7_err_255", error, 1);
    chk("t7_code", err_code, 3);

    // A 254-cycle gap is tolerated
    reload();
    send(8'hA5, 0); send(8'h04, 0); send(8'h01, 1);
    rx_valid = 1'b0;
    for (int i = 0; i < 254; i++) tick();
    send(8'h02, 1);
    chk("t8_no_err", error, 0);
    send(8'h03, 1); send(8'h04, 1); send(8'hF6, 0);
    rx_valid = 1'b0;
    chk("t8_run", cpu_run, 1);
    chk("t8_count", byte_count, 4);

    // Reload from RUN with data offered on the same cycle
    load_req = 1'b1; rx_valid = 1'b1; rx_data = 8'hA5;
    chk("t9_ready", rx_ready, 0);
    tick();
    load_req = 1'b0;
    chk("t9_run_off", cpu_run, 0);
    chk("t9_clear", mem_clear, 1);
    tick();
    chk("t9_sync_busy", busy, 1);
    send(8'hA5, 0); send(8'h03, 0); send(8'h11, 1);

    // Asynchronous reset mid-DATA
    Reset = 1'b1;
    #1;
    chk("t10_busy", busy, 0);
    chk("t10_count", byte_count, 0);
    chk("t10_ready", rx_ready, 0);
    chk("t10_wr", mem_WR, 0);
    chk("t10_run", cpu_run, 0);
    Reset = 1'b0; rx_valid = 1'b0;
    tick(); tick();
    chk("t10_halted", cpu_run, 0);
    chk("t10_idle", busy, 0);
    chk("t10_drain", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
